// File: rtl/ysyx_24100029_icache.sv
// Direct-mapped blocking I-cache between the IFU AXI4 read port and the memory-side crossbar.
// Latency: hit returns s_rvalid two cycles after the AR handshake; a miss returns it one cycle after the m_rlast beat.
// Backpressure: one request in flight, s_arready low outside IDLE; m_arvalid held until accepted; RESP holds until s_rready.
//
// Ports:
//   clock, reset (sync, active-high), fence_i (one-cycle invalidate-all pulse)
//   s_ar*/s_r*  : IFU side, single-beat 4-byte fetches
//   m_ar*/m_r*  : refill side, one INCR burst of LINE_WORDS beats per miss
//   hit_cnt, miss_cnt : lookup performance counters, present only when ICACHE_PERF_EN is defined
module ysyx_24100029_icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fence_i,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_AR,
    MISS_R,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  // Latched fetch address, byte offset dropped (fetches are word aligned).
  logic [29:0]      word_addr;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [31:0]      data_arr [SETS][LINE_WORDS];

  logic [OFF_W-1:0] beat_cnt;
  logic             err_q;       // any refill beat so far returned a nonzero response
  logic             flush_pend;  // fence_i seen while this line was being filled
  logic             lookup_hit;
  logic             rd_err;

  logic unused_lsb;
  assign unused_lsb = ^s_araddr[1:0];

  assign req_off = word_addr[OFF_W-1:0];
  assign req_idx = word_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = word_addr[29:OFF_W+IDX_W];

  // A fence in the lookup cycle wins: the set is being invalidated, so report a miss.
  assign lookup_hit = valid_q[req_idx] && (tag_arr[req_idx] == req_tag) && !fence_i;

  // Error status including the beat arriving this cycle.
  assign rd_err = err_q || (m_rresp != 2'b00);

  assign m_araddr  = {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign s_rlast   = s_rvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    case (state)
      IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) next_state = LOOKUP;
      end
      LOOKUP: begin
        next_state = lookup_hit ? RESP : MISS_AR;
      end
      MISS_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) next_state = MISS_R;
      end
      MISS_R: begin
        m_rready = 1'b1;
        // The beat counter is only a write pointer; the burst ends on m_rlast.
        if (m_rvalid && m_rlast) next_state = RESP;
      end
      RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      word_addr  <= '0;
      s_rdata    <= '0;
      s_rresp    <= 2'b00;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (fence_i) valid_q <= '0;
      case (state)
        IDLE: begin
          if (s_arvalid) word_addr <= s_araddr[31:2];
        end
        LOOKUP: begin
          if (lookup_hit) begin
            s_rdata <= data_arr[req_idx][req_off];
            s_rresp <= 2'b00;
          end else begin
            // A fence in this cycle precedes the fill, so it does not block validation.
            err_q      <= 1'b0;
            flush_pend <= 1'b0;
          end
        end
        MISS_AR: begin
          if (fence_i)   flush_pend <= 1'b1;
          if (m_arready) beat_cnt   <= '0;
        end
        MISS_R: begin
          if (fence_i) flush_pend <= 1'b1;
          if (m_rvalid) begin
            beat_cnt <= beat_cnt + OFF_W'(1);
            err_q    <= rd_err;
            if (beat_cnt == req_off) s_rdata <= m_rdata;
            if (m_rlast) begin
              // Written after the fence clear above, so this bit wins for the filled set;
              // a same-cycle fence still keeps it invalid.
              valid_q[req_idx] <= !(rd_err || flush_pend || fence_i);
              s_rresp          <= rd_err ? 2'b10 : 2'b00;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (state == MISS_R && m_rvalid) begin
      data_arr[req_idx][beat_cnt] <= m_rdata;
      if (m_rlast) tag_arr[req_idx] <= req_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
      else            miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24100029_icache.sv
// Directed bench for ysyx_24100029_icache (LINE_WORDS=4, SETS=16).
// Fixed-cycle stimulus; every expectation comes from the vector table below.
// Refill beats are base+0..base+3; the refill port accepts AR one cycle late.
module tb_ysyx_24100029_icache;

  localparam int LW = 4;

  logic        clock;
  logic        reset;
  logic        fence_i;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int          exp_hits;
  int          exp_misses;
`endif

  int checks;
  int errors;

  ysyx_24100029_icache #(.LINE_WORDS(LW), .SETS(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .fence_i   (fence_i),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        hit;         // expected lookup result
    logic [31:0] base;        // refill beat i carries base+i
    int          err_beat;    // beat with rresp=2'b10, -1 for none
    int          fence_beat;  // beat carrying fence_i, -1 for none
    logic        fence_lk;    // fence_i during the LOOKUP cycle
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic do_fetch(input int id, input vec_t v);
    string p;
    p = $sformatf("v%0d", id);
    s_araddr  = v.addr;
    s_arvalid = 1'b1;
    chk({p, "_arready"}, 32'(s_arready), 32'd1);
    @(posedge clock); #1;
    s_arvalid = 1'b0;
    chk({p, "_lookup_quiet"}, {30'd0, s_rvalid, m_arvalid}, 32'd0);
    if (v.fence_lk) fence_i = 1'b1;
    @(posedge clock); #1;
    fence_i = 1'b0;
    chk({p, "_rvalid_t2"}, 32'(s_rvalid), 32'(v.hit));
    chk({p, "_arvalid_t2"}, 32'(m_arvalid), 32'(!v.hit));
`ifdef ICACHE_PERF_EN
    if (v.hit) exp_hits++;
    else       exp_misses++;
`endif
    if (!v.hit) begin
      chk({p, "_araddr"}, m_araddr, v.addr & 32'hFFFF_FFF0);
      chk({p, "_arlen"}, 32'(m_arlen), 32'd3);
      chk({p, "_arsize_burst"}, {27'd0, m_arsize, m_arburst}, {27'd0, 3'b010, 2'b01});
      @(posedge clock); #1;
      chk({p, "_ar_hold"}, {31'd0, m_arvalid}, 32'd1);
      chk({p, "_araddr_stable"}, m_araddr, v.addr & 32'hFFFF_FFF0);
      m_arready = 1'b1;
      @(posedge clock); #1;
      m_arready = 1'b0;
      chk({p, "_rready"}, {30'd0, m_rready, m_arvalid}, 32'd2);
      for (int b = 0; b < LW; b++) begin
        m_rvalid = 1'b1;
        m_rdata  = v.base + 32'(b);
        m_rresp  = (b == v.err_beat) ? 2'b10 : 2'b00;
        m_rlast  = (b == LW - 1);
        fence_i  = (b == v.fence_beat);
        @(posedge clock); #1;
        fence_i = 1'b0;
        if (b < LW - 1) chk({p, "_no_early_rvalid"}, 32'(s_rvalid), 32'd0);
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      m_rresp  = 2'b00;
      chk({p, "_rvalid_after_last"}, {30'd0, s_rvalid, m_rready}, 32'd2);
    end
    chk({p, "_rdata"}, s_rdata, v.rdata);
    chk({p, "_rresp_rlast"}, {29'd0, s_rresp, s_rlast}, {29'd0, v.rresp, 1'b1});
`ifdef ICACHE_PERF_EN
    chk({p, "_hit_cnt"}, hit_cnt, 32'(exp_hits));
    chk({p, "_miss_cnt"}, miss_cnt, 32'(exp_misses));
`endif
    @(posedge clock); #1;
    chk({p, "_back_idle"}, {30'd0, s_rvalid, s_arready}, 32'd1);
  endtask

  vec_t rv;

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    fence_i    = 1'b0;
    s_arvalid  = 1'b0;
    s_araddr   = 32'd0;
    s_rready   = 1'b1;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = 32'd0;
    m_rresp    = 2'b00;
    m_rlast    = 1'b0;
`ifdef ICACHE_PERF_EN
    exp_hits   = 0;
    exp_misses = 0;
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    chk("rst_arready", 32'(s_arready), 32'd1);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_rresp", 32'(s_rresp), 32'd0);
    chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_m_rready", 32'(m_rready), 32'd0);
`ifdef ICACHE_PERF_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    //            addr          hit   base    err fence lk    rdata         rresp
    vecs[0]  = '{32'h30000004, 1'b0, 32'hA0, -1, -1, 1'b0, 32'hA1, 2'b00}; // cold miss
    vecs[1]  = '{32'h30000008, 1'b1, 32'h00, -1, -1, 1'b0, 32'hA2, 2'b00}; // hit
    vecs[2]  = '{32'h3000000C, 1'b1, 32'h00, -1, -1, 1'b0, 32'hA3, 2'b00};
    vecs[3]  = '{32'h30000100, 1'b0, 32'hB0, -1, -1, 1'b0, 32'hB0, 2'b00}; // conflict, set 0
    vecs[4]  = '{32'h30000104, 1'b1, 32'h00, -1, -1, 1'b0, 32'hB1, 2'b00};
    vecs[5]  = '{32'h30000000, 1'b0, 32'hC0, -1, -1, 1'b0, 32'hC0, 2'b00}; // evicted line
    vecs[6]  = '{32'h30000010, 1'b0, 32'hD0,  2, -1, 1'b0, 32'hD0, 2'b10}; // error beat 2
    vecs[7]  = '{32'h30000014, 1'b0, 32'hE0, -1, -1, 1'b0, 32'hE1, 2'b00}; // not cached
    vecs[8]  = '{32'h30000018, 1'b1, 32'h00, -1, -1, 1'b0, 32'hE2, 2'b00};
    vecs[9]  = '{32'h30000028, 1'b0, 32'hF0, -1,  1, 1'b0, 32'hF2, 2'b00}; // fence mid-fill
    vecs[10] = '{32'h30000028, 1'b0, 32'h50, -1, -1, 1'b0, 32'h52, 2'b00};
    vecs[11] = '{32'h30000020, 1'b1, 32'h00, -1, -1, 1'b0, 32'h50, 2'b00};
    vecs[12] = '{32'h30000008, 1'b0, 32'h60, -1, -1, 1'b0, 32'h62, 2'b00}; // flushed set 0
    vecs[13] = '{32'h30000034, 1'b0, 32'h70, -1,  3, 1'b0, 32'h71, 2'b00}; // fence on rlast
    vecs[14] = '{32'h30000034, 1'b0, 32'h78, -1, -1, 1'b0, 32'h79, 2'b00};
    vecs[15] = '{32'h30000030, 1'b1, 32'h00, -1, -1, 1'b0, 32'h78, 2'b00};
    vecs[16] = '{32'h30000030, 1'b0, 32'h90, -1, -1, 1'b1, 32'h90, 2'b00}; // fence in LOOKUP
    vecs[17] = '{32'h30000034, 1'b1, 32'h00, -1, -1, 1'b0, 32'h91, 2'b00};

    for (int i = 0; i < 18; i++) begin
      do_fetch(i, vecs[i]);
    end

    // Reset in the middle of a refill burst.
    s_araddr  = 32'h30000040;
    s_arvalid = 1'b1;
    @(posedge clock); #1;
    s_arvalid = 1'b0;
    @(posedge clock); #1;
    chk("mr_arvalid", 32'(m_arvalid), 32'd1);
    m_arready = 1'b1;
    @(posedge clock); #1;
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'h1234;
    @(posedge clock); #1;
    chk("mr_in_refill", {30'd0, m_rready, s_arready}, 32'd2);
    m_rvalid = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mr_rst_arready", 32'(s_arready), 32'd1);
    chk("mr_rst_quiet", {29'd0, m_rready, m_arvalid, s_rvalid}, 32'd0);
`ifdef ICACHE_PERF_EN
    exp_hits   = 0;
    exp_misses = 0;
    chk("mr_rst_miss_cnt", miss_cnt, 32'd0);
`endif
    // 0x30000030 was valid before the reset; it must miss now.
    rv = '{32'h30000030, 1'b0, 32'h20, -1, -1, 1'b0, 32'h20, 2'b00};
    do_fetch(100, rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_24100029_icache.md
# ysyx_24100029_icache

Direct-mapped, blocking instruction cache between the IFU's AXI4 read channel and the memory-side AXI4 crossbar. It accepts single-beat 4-byte fetches from the IFU and returns hits from on-chip line storage. Misses are refilled with one INCR burst of a full line. A `fence_i` pulse invalidates the whole cache.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, 2..16.
- `SETS`, default 16: number of lines; power of two.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `fence_i`  in  1  one-cycle invalidate-all pulse.
- `s_arvalid` / `s_arready`  in / out  1 / 1  IFU address handshake.
- `s_araddr`  in  32  fetch address, word aligned; IFU drives arlen 0, arsize 3'b010.
- `s_rvalid` / `s_rready`  out / in  1 / 1  IFU data handshake.
- `s_rdata`  out  32  instruction word.
- `s_rresp`  out  2  response code.
- `s_rlast`  out  1  equals `s_rvalid`.
- `m_arvalid` / `m_arready`  out / in  1 / 1  refill address handshake.
- `m_araddr`  out  32  line-aligned refill address.
- `m_arlen`  out  8  constant LINE_WORDS-1.
- `m_arsize`  out  3  constant 3'b010.
- `m_arburst`  out  2  constant 2'b01 (INCR).
- `m_rvalid` / `m_rready`  in / out  1 / 1  refill beats.
- `m_rdata`  in  32  refill beat data.
- `m_rresp`  in  2  refill beat response.
- `m_rlast`  in  1  final refill beat.
- `hit_cnt`, `miss_cnt`  out  32 / 32  performance counters; present only with `ICACHE_PERF_EN`.

## Operation
- Address split: offset = log2(LINE_WORDS)+2 bits (low 2 ignored); index = log2(SETS) bits; tag = remaining upper bits.
- Storage: data array, tag array and valid array, all registers. Reset clears every valid bit. Data and tag contents are don't-care after reset.
- FSM states: IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
- IDLE: `s_arready`=1. On handshake, latch `s_araddr` and go to LOOKUP.
- LOOKUP: compare tag and valid for the latched index.
  - Hit: capture the word into the `s_rdata` register, set `s_rresp`=0, go to RESP.
  - Miss: go to MISS_AR.
- MISS_AR: `m_arvalid`=1, `m_araddr`={tag,index,0}. On `m_arready`, reset the beat counter and go to MISS_R.
- MISS_R: `m_rready`=1. Each beat is written to word[counter] and the counter increments.
  - When counter equals the requested offset, capture `m_rdata` into `s_rdata`.
  - Any nonzero `m_rresp` sets a sticky error flag.
  - On `m_rlast`: write the tag; set the valid bit only if there is no error and no flush occurred during the fill. Go to RESP with `s_rresp`=error ? 2'b10 : 2'b00.
- RESP: `s_rvalid`=1. On `s_rready`, go to IDLE. The IFU holds rready high, so RESP normally lasts one cycle.
- `fence_i`:
  - Clears all valid bits in the same cycle, in any state.
  - In MISS_AR or MISS_R, also sets a pending flag so the in-flight line is not validated.
  - The outstanding fetch still completes with its data.
- Cache holds at most one outstanding request; `s_arready`=0 outside IDLE.

## Timing
- Reset values:
  - `s_arready`=1 (state IDLE); `s_rvalid`=0; `s_rdata`=0; `s_rresp`=0.
  - `m_arvalid`=0; `m_rready`=0; counters 0.
- Hit latency: AR handshake in cycle T, LOOKUP in T+1, `s_rvalid` in T+2.
- Miss latency: `m_arvalid` in T+2; `s_rvalid` the cycle after the `m_rlast` beat.
- `m_arvalid` is held until accepted; `m_araddr` is stable while `m_arvalid`=1.
- `fence_i` in the same cycle as LOOKUP: the flush takes priority and the lookup is treated as a miss.
- `fence_i` in the same cycle as the `m_rlast` beat: the line is not validated.
- Reset in any state returns to IDLE next cycle and drops all valid bits, `m_arvalid` and `s_rvalid`. A burst abandoned mid-flight is the interconnect's responsibility.
- The beat counter wraps at LINE_WORDS. `m_rlast` alone ends MISS_R.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `hit_cnt` increments on each LOOKUP hit; `miss_cnt` increments on each LOOKUP miss.
  - Both reset to 0 and wrap modulo 2^32.
- `ICACHE_PERF_EN` undefined: both counter ports and their logic are absent; functional behaviour is identical.

## Test plan
- Cold miss, fetch 0x30000004: `m_araddr`=0x30000000, `m_arlen`=3, `m_arburst`=01. Beats 0xA0..0xA3 → `s_rdata`=0xA1, `s_rresp`=0, `s_rvalid` one cycle after `m_rlast`.
- Then fetch 0x30000008: hit, no `m_arvalid`, `s_rdata`=0xA2 exactly two cycles after the AR handshake; `hit_cnt`=1, `miss_cnt`=1.
- Conflict: fetch 0x30000100 (same index 0, different tag) → refill. A following fetch of 0x30000000 misses again.
- Refill with `m_rresp`=2'b10 on beat 2 → `s_rresp`=2'b10; re-fetching the same address misses.
- `fence_i` asserted during MISS_R → the current fetch returns correct data; a re-fetch of the same line misses.
- Reset asserted in MISS_R → next cycle: IDLE, `s_arready`=1, `m_rready`=0, first fetch afterwards misses.
